// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Read support is built only when I2C_SLAVE_READ_EN is defined.
package i2c_pkg;

  localparam int BYTE_W = 8;
  localparam int RW_BIT = 0;

  localparam logic RW_READ   = 1'b1;
  localparam logic ACK_BIT   = 1'b0;
  localparam logic NACK_BIT  = 1'b1;
  localparam logic START_SDA = 1'b0;
  localparam logic STOP_SDA  = 1'b1;

  localparam logic [6:0] GCALL_ADDR = 7'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with registered edge and START/STOP pulses.
// Pin change to pulse output takes three clocks.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [1:0] scl_s;
  logic [1:0] sda_s;
  logic       scl_q;
  logic       sda_q;

  // Two-flop synchronizers, a history flop and registered event pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s     <= 2'b11;
      sda_s     <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_s     <= {scl_s[0], scl_in};
      sda_s     <= {sda_s[0], sda_in};
      scl_q     <= scl_s[1];
      sda_q     <= sda_s[1];
      scl_rise  <= scl_s[1] & ~scl_q;
      scl_fall  <= ~scl_s[1] & scl_q;
      start_det <= scl_s[1] & scl_q
                 & (sda_q != START_SDA)
                 & (sda_s[1] == START_SDA);
      stop_det  <= scl_s[1] & scl_q
                 & (sda_q != STOP_SDA)
                 & (sda_s[1] == STOP_SDA);
    end
  end

  assign sda = sda_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: address match, register pointer, write and read data.
// Read transfers are built only when I2C_SLAVE_READ_EN is defined.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);

  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic              sda;
  state_t            state;
  logic [2:0]        cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] nbyte;
  logic              ack_on;
  logic              hit;
  logic              last;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  assign nbyte = {shreg[BYTE_W-2:0], sda};
  assign last  = (cnt == 3'd7);

`ifdef I2C_SLAVE_READ_EN
  logic rd_mode;

  assign hit = (nbyte[7:1] == SLAVE_ADDR)
             && (nbyte[7:1] != GCALL_ADDR);
`else
  logic unused_rdata;

  assign unused_rdata = ^reg_rdata;
  assign reg_rd       = 1'b0;
  assign hit = (nbyte[7:1] == SLAVE_ADDR)
             && (nbyte[7:1] != GCALL_ADDR)
             && (nbyte[RW_BIT] != RW_READ);
`endif

  // Protocol FSM: framing, ACK driving, pointer and register strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      busy      <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rd_mode   <= 1'b0;
      reg_rd    <= 1'b0;
`endif
    end else begin
      reg_wr <= 1'b0;
      if (reg_wr) reg_addr <= reg_addr + 8'd1;
`ifdef I2C_SLAVE_READ_EN
      reg_rd <= 1'b0;
      if (reg_rd) begin
        shreg  <= reg_rdata;
        sda_oe <= ~reg_rdata[BYTE_W-1];
      end
`endif
      if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end else if (start_det) begin
        state  <= S_ADDR;
        sda_oe <= 1'b0;
        cnt    <= '0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              shreg <= nbyte;
              cnt   <= cnt + 3'd1;
              if (last) begin
                if (hit) begin
                  state <= S_ADDR_ACK;
                  busy  <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                  rd_mode <= nbyte[RW_BIT];
`endif
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= ~ACK_BIT;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                cnt    <= '0;
                state  <= S_WDATA;
                if (state == S_ADDR_ACK) state <= S_REG;
`ifdef I2C_SLAVE_READ_EN
                if (state == S_ADDR_ACK && rd_mode == RW_READ) begin
                  state  <= S_RDATA;
                  reg_rd <= 1'b1;
                end
`endif
              end
            end
          end
          S_REG, S_WDATA: begin
            if (scl_rise) begin
              shreg <= nbyte;
              cnt   <= cnt + 3'd1;
              if (last) begin
                if (state == S_REG) begin
                  reg_addr <= nbyte;
                  state    <= S_REG_ACK;
                end else begin
                  reg_wdata <= nbyte;
                  reg_wr    <= 1'b1;
                  state     <= S_WDATA_ACK;
                end
              end
            end
          end
`ifdef I2C_SLAVE_READ_EN
          S_RDATA: begin
            if (scl_fall) begin
              if (last) begin
                sda_oe <= 1'b0;
                cnt    <= '0;
                ack_on <= 1'b0;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~shreg[BYTE_W-2];
                shreg  <= shreg << 1;
                cnt    <= cnt + 3'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda == NACK_BIT) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                reg_addr <= reg_addr + 8'd1;
                ack_on   <= 1'b1;
              end
            end
            if (scl_fall && ack_on) begin
              reg_rd <= 1'b1;
              cnt    <= '0;
              ack_on <= 1'b0;
              state  <= S_RDATA;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
